// File: rtl/mem_system.sv
// Accumulator datapath: 8-entry register bank, ALU and shifter, C/N/P/Z flags, IR, MAR, MDR and a RAM
// addressed by MAR. Driven one micro-op per clock by external control strobes.
`timescale 1ns/1ps
module mem_system #(
  parameter int    DATA_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_sclr,
  input  logic                  mar_sclr,
  input  logic                  enaf,
  input  logic [2:0]            selop,
  input  logic [1:0]            shamt,
  input  logic                  bank_wr_en,
  input  logic [2:0]            busB_addr,
  input  logic [2:0]            busC_addr,
  input  logic                  ir_en,
  input  logic                  mar_en,
  input  logic                  wr_rdn,
  input  logic                  mdr_alu_n,
  input  logic                  mdr_en,
  output logic [DATA_WIDTH-1:0] busC_m,
  output logic [DATA_WIDTH-1:0] bus_alu_m,
  output logic [DATA_WIDTH-1:0] PC_m,
  output logic [DATA_WIDTH-1:0] DPTR_m,
  output logic [DATA_WIDTH-1:0] A_m,
  output logic [DATA_WIDTH-1:0] TEMP_m,
  output logic [DATA_WIDTH-1:0] ACC_m,
  output logic [4:0]            instruction,
  output logic                  C,
  output logic                  N,
  output logic                  P,
  output logic                  Z
);
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 2 ** DW;

  logic [DW-1:0] bank [8];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mar, mdr, ir;
  logic [DW-1:0] bus_b, bus_c, acc, alu_res, shift_res, mem_rd;
  logic [DW:0]   wide;
  logic          alu_carry, shift_carry;

  assign acc    = bank[7];
  assign bus_b  = bank[busB_addr];
  assign mem_rd = mem[mar];

  // The carry comes out of a DW+1 bit sum; for subtraction the top bit is the borrow.
  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (selop)
      3'b000: alu_res = bus_b;
      3'b001: begin
        wide      = {1'b0, acc} + {1'b0, bus_b};
        alu_res   = wide[DW-1:0];
        alu_carry = wide[DW];
      end
      3'b010: begin
        wide      = {1'b0, acc} - {1'b0, bus_b};
        alu_res   = wide[DW-1:0];
        alu_carry = wide[DW];
      end
      3'b011: alu_res = acc & bus_b;
      3'b100: alu_res = acc | bus_b;
      3'b101: alu_res = acc ^ bus_b;
      3'b110: begin
        wide      = {1'b0, bus_b} + (DW+1)'(1);
        alu_res   = wide[DW-1:0];
        alu_carry = wide[DW];
      end
      default: alu_res = ~bus_b;
    endcase
  end

  // A shift replaces the ALU carry with the bit shifted out.
  always_comb begin
    shift_res   = alu_res;
    shift_carry = alu_carry;
    case (shamt)
      2'b01: begin
        shift_res   = {alu_res[DW-2:0], 1'b0};
        shift_carry = alu_res[DW-1];
      end
      2'b10: begin
        shift_res   = {1'b0, alu_res[DW-1:1]};
        shift_carry = alu_res[0];
      end
      2'b11: begin
        shift_res   = {alu_res[DW-1], alu_res[DW-1:1]};
        shift_carry = alu_res[0];
      end
      default: ;
    endcase
  end

  assign bus_c = mdr_alu_n ? mdr : shift_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (bank_wr_en) begin
      bank[busC_addr] <= bus_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
    end else begin
      if (mar_sclr)    mar <= '0;
      else if (mar_en) mar <= bus_c;
      if (mdr_en)      mdr <= wr_rdn ? shift_res : mem_rd;
      if (ir_sclr)     ir  <= '0;
      else if (ir_en)  ir  <= mdr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C <= 1'b0;
      N <= 1'b0;
      P <= 1'b0;
      Z <= 1'b0;
    end else if (enaf) begin
      C <= shift_carry;
      N <= shift_res[DW-1];
      P <= ^shift_res;
      Z <= (shift_res == '0);
    end
  end

  // RAM keeps its contents through reset; a write stores the MDR value held before the edge.
  always_ff @(posedge clk) begin
    if (wr_rdn) mem[mar] <= mdr;
  end

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  assign busC_m      = bus_c;
  assign bus_alu_m   = shift_res;
  assign PC_m        = bank[0];
  assign DPTR_m      = bank[1];
  assign A_m         = bank[2];
  assign TEMP_m      = bank[3];
  assign ACC_m       = bank[7];
  assign instruction = ir[DW-1:DW-5];

endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: fetch, direct load, ALU/shifter/flags, IR and store/read-back,
// with RAM preloaded through the datapath itself.
`timescale 1ns/1ps
module tb_mem_system;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn, mdr_alu_n, mdr_en;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic [7:0] busC_m, bus_alu_m, PC_m, DPTR_m, A_m, TEMP_m, ACC_m;
  logic [4:0] instruction;
  logic       C, N, P, Z;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] alu_exp [8] = '{8'h5A, 8'h01, 8'h4D, 8'h02, 8'hFF, 8'hFD, 8'h5B, 8'hA5};

  mem_system dut (
    .clk(clk), .rst(rst), .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf),
    .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
    .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .wr_rdn(wr_rdn),
    .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en), .busC_m(busC_m), .bus_alu_m(bus_alu_m),
    .PC_m(PC_m), .DPTR_m(DPTR_m), .A_m(A_m), .TEMP_m(TEMP_m), .ACC_m(ACC_m),
    .instruction(instruction), .C(C), .N(N), .P(P), .Z(Z)
  );

  // clock / watchdog
  always #50 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic idle();
    ir_sclr = 0; mar_sclr = 0; enaf = 0; bank_wr_en = 0; ir_en = 0; mar_en = 0;
    wr_rdn = 0; mdr_alu_n = 0; mdr_en = 0; selop = 3'b000; shamt = 2'b00;
    busB_addr = 3'd0; busC_addr = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds a constant in bank[idx] from the never-written bank[6] by shift-and-increment.
  task automatic load_reg(input logic [2:0] idx, input logic [7:0] val);
    idle(); busB_addr = 3'd6; bank_wr_en = 1; busC_addr = idx; tick();
    for (int b = 7; b >= 0; b--) begin
      idle(); shamt = 2'b01; busB_addr = idx; bank_wr_en = 1; busC_addr = idx; tick();
      if (val[b]) begin
        idle(); selop = 3'b110; busB_addr = idx; bank_wr_en = 1; busC_addr = idx; tick();
      end
    end
    idle();
  endtask

  task automatic poke_mem(input logic [7:0] addr, input logic [7:0] val);
    load_reg(3'd4, addr);
    load_reg(3'd5, val);
    idle(); mar_en = 1; busB_addr = 3'd4; tick();
    idle(); mdr_en = 1; wr_rdn = 1; busB_addr = 3'd5; tick();
    idle(); wr_rdn = 1; tick();
    idle();
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {4'b0000, C, N, P, Z};
  endfunction

  initial begin
    idle();
    rst = 0;
    #130;
    rst = 1;
    @(negedge clk);
    poke_mem(8'h05, 8'hA7);
    poke_mem(8'h00, 8'h05);

    // asynchronous reset between edges; RAM contents must survive it
    #20;
    rst = 0;
    #1;
    check("reset PC", PC_m, 8'h00);
    check("reset ACC", ACC_m, 8'h00);
    check("reset DPTR/A/TEMP", DPTR_m | A_m | TEMP_m, 8'h00);
    check("reset busC", busC_m, 8'h00);
    check("reset bus_alu", bus_alu_m, 8'h00);
    check("reset instruction", {3'b000, instruction}, 8'h00);
    check("reset flags", flags(), 8'h00);
    @(negedge clk);
    rst = 1;

    // fetch
    idle(); mar_en = 1; busB_addr = 3'd0; tick();
    idle(); selop = 3'b110; busB_addr = 3'd0; bank_wr_en = 1; busC_addr = 3'd0; mdr_en = 1; tick();
    check("fetch PC", PC_m, 8'h01);
    idle(); mdr_alu_n = 1; #1;
    check("fetch MDR", busC_m, 8'h05);

    // mov acc,[dir]
    idle(); mar_en = 1; mdr_alu_n = 1; tick();
    idle(); mdr_en = 1; tick();
    idle(); mdr_alu_n = 1; #1;
    check("dir MDR", busC_m, 8'hA7);
    idle(); bank_wr_en = 1; busC_addr = 3'd7; mdr_alu_n = 1; tick();
    check("mov ACC", ACC_m, 8'hA7);

    // IR
    idle(); ir_en = 1; tick();
    check("IR load", {3'b000, instruction}, 8'h14);
    idle(); ir_sclr = 1; ir_en = 1; tick();
    check("IR sclr", {3'b000, instruction}, 8'h00);

    // ALU table, ACC=A7 B=5A
    load_reg(3'd2, 8'h5A);
    check("load A", A_m, 8'h5A);
    for (int i = 0; i < 8; i++) begin
      idle(); selop = 3'(i); busB_addr = 3'd2; #1;
      check($sformatf("alu op%0d", i), bus_alu_m, alu_exp[i]);
    end
    idle(); selop = 3'b001; busB_addr = 3'd2; enaf = 1; tick();
    check("add carry flags", flags(), 8'h0A);

    load_reg(3'd2, 8'hC0);
    idle(); selop = 3'b010; busB_addr = 3'd2; enaf = 1; #1;
    check("sub borrow", bus_alu_m, 8'hE7);
    tick();
    check("sub borrow flags", flags(), 8'h0C);

    // ACC=FF + 1 wraps
    load_reg(3'd7, 8'hFF);
    load_reg(3'd2, 8'h01);
    idle(); selop = 3'b001; busB_addr = 3'd2; enaf = 1; #1;
    check("add wrap", bus_alu_m, 8'h00);
    tick();
    check("add wrap flags", flags(), 8'h09);
    idle(); selop = 3'b100; busB_addr = 3'd2; tick();
    check("flags hold", flags(), 8'h09);
    idle(); selop = 3'b001; busB_addr = 3'd2; shamt = 2'b10; enaf = 1; #1;
    check("add srl", bus_alu_m, 8'h00);
    tick();
    check("shift carry override", flags(), 8'h01);
    idle(); selop = 3'b110; busB_addr = 3'd7; enaf = 1; #1;
    check("inc wrap", bus_alu_m, 8'h00);
    tick();
    check("inc wrap flags", flags(), 8'h09);

    // shifter on B=81
    load_reg(3'd2, 8'h81);
    idle(); busB_addr = 3'd2; shamt = 2'b01; enaf = 1; #1;
    check("sll", bus_alu_m, 8'h02);
    tick();
    check("sll flags", flags(), 8'h0A);
    idle(); busB_addr = 3'd2; shamt = 2'b10; enaf = 1; #1;
    check("srl", bus_alu_m, 8'h40);
    tick();
    check("srl flags", flags(), 8'h0A);
    idle(); busB_addr = 3'd2; shamt = 2'b11; enaf = 1; #1;
    check("sra", bus_alu_m, 8'hC0);
    tick();
    check("sra flags", flags(), 8'h0C);

    // store 3C at 0x10 and read it back
    load_reg(3'd3, 8'h10);
    load_reg(3'd4, 8'h3C);
    idle(); mar_en = 1; busB_addr = 3'd3; tick();
    idle(); wr_rdn = 1; mdr_en = 1; busB_addr = 3'd4; tick();
    idle(); mdr_alu_n = 1; #1;
    check("store MDR", busC_m, 8'h3C);
    idle(); wr_rdn = 1; tick();
    idle(); mar_sclr = 1; mar_en = 1; busB_addr = 3'd3; tick();
    idle(); mdr_en = 1; tick();
    idle(); mdr_alu_n = 1; #1;
    check("mar sclr read", busC_m, 8'h05);
    idle(); mar_en = 1; busB_addr = 3'd3; tick();
    idle(); mdr_en = 1; tick();
    idle(); mdr_alu_n = 1; #1;
    check("store readback", busC_m, 8'h3C);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
